uart_io_ctrl: RTL and testbench

//   Sequences the shared byte-wide UART receiver/sender for the CPU core. Routes received

---
 rtl/uart_io_pkg.sv | 23 ++
 rtl/uart_io_ctrl_if.sv | 36 +++
 rtl/uart_word_tx.sv | 94 +++++++++
 rtl/uart_io_ctrl.sv | 143 ++++++++++++++
 tb/tb_uart_io_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_io_pkg.sv
// Shared types and constants for the UART I/O sequencer.
//   rx_state_t : receive-word FSM states
//   tx_state_t : transmit-word FSM states
//   BYTE_W     : width of one UART byte
package uart_io_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    RxIdle,
    RxCollect,
    RxDone
  } rx_state_t;

  typedef enum logic [2:0] {
    TxIdle,
    TxSend,
    TxAck,
    TxDrain,
    TxDone
  } tx_state_t;

endpackage

// File: rtl/uart_io_ctrl_if.sv
// Bundle between the UART sequencer and its environment (receiver, sender, loader, core).
//   master : environment side (drives requests, receiver bytes, sender ready)
//   slave  : sequencer side (drives loader bytes, IN word, sender strobe, done strobes)
interface uart_io_ctrl_if
  import uart_io_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4
);

  logic                           load_mode;
  logic [BYTE_W-1:0]              rx_data;
  logic                           rx_valid;
  logic [BYTE_W-1:0]              ld_data;
  logic                           ld_valid;
  logic                           in_req;
  logic [WORD_BYTES*BYTE_W-1:0]   in_data;
  logic                           in_done;
  logic                           out_req;
  logic [WORD_BYTES*BYTE_W-1:0]   out_word;
  logic                           out_done;
  logic [BYTE_W-1:0]              tx_data;
  logic                           tx_enable;
  logic                           tx_ready;
  logic                           rx_overrun;

  modport master (
    output load_mode, rx_data, rx_valid, in_req, out_req, out_word, tx_ready,
    input  ld_data, ld_valid, in_data, in_done, out_done, tx_data, tx_enable, rx_overrun
  );

  modport slave (
    input  load_mode, rx_data, rx_valid, in_req, out_req, out_word, tx_ready,
    output ld_data, ld_valid, in_data, in_done, out_done, tx_data, tx_enable, rx_overrun
  );

endinterface

// File: rtl/uart_word_tx.sv
// Serialises one word into WORD_BYTES sender bytes, MSB first.
//   clk, rst  : clock, synchronous active-high reset
//   out_req   : level request; out_word latched when accepted in idle
//   tx_ready  : sender idle
//   tx_data   : byte to sender, held from its strobe until the next strobe
//   tx_enable : one-cycle start strobe
//   out_done  : one-cycle strobe once the last byte has fully drained
module uart_word_tx
  import uart_io_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4,
  localparam int unsigned WordW = WORD_BYTES * BYTE_W,
  localparam int unsigned CntW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_req,
  input  logic [WordW-1:0]  out_word,
  input  logic              tx_ready,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_enable,
  output logic              out_done
);

  tx_state_t         state_q, state_d;
  logic [WordW-1:0]  word_q, word_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_en_q, tx_en_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TxIdle;
      word_q    <= '0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    case (state_q)
      TxIdle: begin
        if (out_req) begin
          word_d  = out_word;
          cnt_d   = '0;
          state_d = TxSend;
        end
      end
      TxSend: begin
        // Strobe is registered, so it appears in the first TxAck cycle with its byte.
        if (tx_ready) begin
          tx_data_d = word_q[WordW-1 -: BYTE_W];
          word_d    = word_q << BYTE_W;
          tx_en_d   = 1'b1;
          state_d   = TxAck;
        end
      end
      TxAck: begin
        if (!tx_ready) state_d = TxDrain;
      end
      TxDrain: begin
        if (tx_ready) begin
          if (cnt_q == CntW'(WORD_BYTES - 1)) begin
            state_d = TxDone;
          end else begin
            cnt_d   = cnt_q + CntW'(1);
            state_d = TxSend;
          end
        end
      end
      TxDone:  state_d = TxIdle;
      default: state_d = TxIdle;
    endcase
  end

  always_comb begin
    tx_data   = tx_data_q;
    tx_enable = tx_en_q;
    out_done  = (state_q == TxDone);
  end

endmodule

// File: rtl/uart_io_ctrl.sv
// Sequences the shared UART receiver/sender for the core.
//   CLK, RST : clock, synchronous active-high reset
//   io       : slave side of uart_io_ctrl_if
//              - loader path: receiver bytes forwarded while load_mode=1 (1-cycle latency)
//              - IN path: WORD_BYTES receiver bytes assembled MSB first into in_data
//              - OUT path: out_word serialised by uart_word_tx
//              - one-byte hold register catches bytes arriving before an IN request
module uart_io_ctrl
  import uart_io_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4
) (
  input logic           CLK,
  input logic           RST,
  uart_io_ctrl_if.slave io
);

  localparam int unsigned WordW = WORD_BYTES * BYTE_W;
  localparam int unsigned CntW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  rx_state_t         rx_state_q, rx_state_d;
  logic [CntW-1:0]   k_q, k_d;
  logic [WordW-1:0]  in_data_q, in_data_d;
  logic              hold_full_q, hold_full_d;
  logic [BYTE_W-1:0] hold_data_q, hold_data_d;
  logic              overrun_q, overrun_d;
  logic [BYTE_W-1:0] ld_data_q, ld_data_d;
  logic              ld_valid_q, ld_valid_d;

  logic              take_hold, take_rx;
  logic [BYTE_W-1:0] rx_byte;
  int unsigned       shift;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_state_q  <= RxIdle;
      k_q         <= '0;
      in_data_q   <= '0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      overrun_q   <= 1'b0;
      ld_data_q   <= '0;
      ld_valid_q  <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      k_q         <= k_d;
      in_data_q   <= in_data_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      overrun_q   <= overrun_d;
      ld_data_q   <= ld_data_d;
      ld_valid_q  <= ld_valid_d;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    k_d         = k_q;
    in_data_d   = in_data_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    overrun_d   = overrun_q;
    ld_data_d   = ld_data_q;
    ld_valid_d  = 1'b0;
    take_hold   = 1'b0;
    take_rx     = 1'b0;
    rx_byte     = io.rx_data;
    shift       = BYTE_W * 32'(k_q);

    if (io.load_mode && io.rx_valid) begin
      ld_valid_d = 1'b1;
      ld_data_d  = io.rx_data;
    end

    case (rx_state_q)
      RxIdle: begin
        if (io.in_req && !io.load_mode) begin
          k_d        = '0;
          rx_state_d = RxCollect;
        end
      end
      RxCollect: begin
        if (io.load_mode) begin
          rx_state_d = RxIdle;  // partial word dropped, no in_done
        end else begin
          // A held byte is older than anything on the receiver, so it goes first.
          if (hold_full_q) begin
            take_hold = 1'b1;
            rx_byte   = hold_data_q;
          end else if (io.rx_valid) begin
            take_rx = 1'b1;
          end
          if (take_hold || take_rx) begin
            in_data_d = (in_data_q & ~({{BYTE_W{1'b1}}, {(WordW-BYTE_W){1'b0}}} >> shift))
                      | ({rx_byte, {(WordW-BYTE_W){1'b0}}} >> shift);
            if (k_q == CntW'(WORD_BYTES - 1)) begin
              rx_state_d = RxDone;
            end else begin
              k_d = k_q + CntW'(1);
            end
          end
        end
      end
      RxDone:  rx_state_d = RxIdle;
      default: rx_state_d = RxIdle;
    endcase

    // Any IN-mode byte not consumed directly lands in the hold register; this also covers a
    // byte arriving in the acceptance cycle, which then becomes byte 0 one cycle later.
    if (io.load_mode) begin
      hold_full_d = 1'b0;
    end else begin
      if (take_hold) hold_full_d = 1'b0;
      if (io.rx_valid && !take_rx) begin
        hold_full_d = 1'b1;
        hold_data_d = io.rx_data;
        if (hold_full_q && !take_hold) overrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    io.ld_data    = ld_data_q;
    io.ld_valid   = ld_valid_q;
    io.in_data    = in_data_q;
    io.in_done    = (rx_state_q == RxDone);
    io.rx_overrun = overrun_q;
  end

  uart_word_tx #(
    .WORD_BYTES(WORD_BYTES)
  ) u_tx (
    .clk      (CLK),
    .rst      (RST),
    .out_req  (io.out_req),
    .out_word (io.out_word),
    .tx_ready (io.tx_ready),
    .tx_data  (io.tx_data),
    .tx_enable(io.tx_enable),
    .out_done (io.out_done)
  );

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Scoreboard bench for uart_io_ctrl: stimulus pushes expected loader bytes, IN words, sender
// bytes and OUT completions into queues; a negedge monitor pops and compares them.
module tb_uart_io_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  uart_io_ctrl_if #(.WORD_BYTES(4)) bus ();

  uart_io_ctrl #(
    .WORD_BYTES(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .io (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  ld_q[$];
  logic [31:0] in_q[$];
  logic [7:0]  tx_q[$];
  int          done_q[$];
  int          tx_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event unexpected or missing (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    tick();
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_in_done();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      if (bus.in_done) seen = 1'b1;
    end
    #1;
    bus.in_req = 1'b0;
    if (!seen) flag("in_done_timeout");
  endtask

  task automatic wait_out_done();
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge CLK);
      if (bus.out_done) seen = 1'b1;
    end
    #1;
    if (!seen) flag("out_done_timeout");
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ld_valid"},   32'(bus.ld_valid),   32'd0);
    check({tag, "_ld_data"},    32'(bus.ld_data),    32'd0);
    check({tag, "_in_data"},    bus.in_data,         32'd0);
    check({tag, "_in_done"},    32'(bus.in_done),    32'd0);
    check({tag, "_tx_enable"},  32'(bus.tx_enable),  32'd0);
    check({tag, "_tx_data"},    32'(bus.tx_data),    32'd0);
    check({tag, "_out_done"},   32'(bus.out_done),   32'd0);
    check({tag, "_rx_overrun"}, 32'(bus.rx_overrun), 32'd0);
  endtask

  // Sender model: busy for 20 cycles after each start strobe.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(negedge CLK);
      if (bus.tx_enable) begin
        #2 bus.tx_ready = 1'b0;
        repeat (20) @(negedge CLK);
        #2 bus.tx_ready = 1'b1;
      end
    end
  end

  // Monitor.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        in_q.delete();
        tx_q.delete();
        done_q.delete();
        tx_seen = 0;
      end else begin
        if (bus.ld_valid) begin
          if (ld_q.size() == 0) flag("ld_valid_unexpected");
          else check("ld_data", 32'(bus.ld_data), 32'(ld_q.pop_front()));
        end
        if (bus.in_done) begin
          if (in_q.size() == 0) flag("in_done_unexpected");
          else check("in_data", bus.in_data, in_q.pop_front());
        end
        if (bus.tx_enable) begin
          check("tx_ready_at_enable", 32'(bus.tx_ready), 32'd1);
          tx_seen++;
          if (tx_q.size() == 0) flag("tx_enable_unexpected");
          else check("tx_data", 32'(bus.tx_data), 32'(tx_q.pop_front()));
        end
        if (bus.out_done) begin
          if (done_q.size() == 0) flag("out_done_unexpected");
          else check("out_done_bytes", 32'(tx_seen), 32'(done_q.pop_front()));
          tx_seen = 0;
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int cnt;
    bus.load_mode = 1'b0;
    bus.rx_data   = '0;
    bus.rx_valid  = 1'b0;
    bus.in_req    = 1'b0;
    bus.out_req   = 1'b0;
    bus.out_word  = '0;

    repeat (3) tick();
    @(negedge CLK);
    #1;
    check_outputs_zero("reset");
    RST = 1'b0;

    // Loader path.
    tick();
    bus.load_mode = 1'b1;
    ld_q.push_back(8'h02); send_rx(8'h02);
    ld_q.push_back(8'h00); send_rx(8'h00);
    ld_q.push_back(8'h00); send_rx(8'h00);
    ld_q.push_back(8'h20); send_rx(8'h20);
    tick();
    bus.load_mode = 1'b0;
    repeat (2) tick();

    // Plain IN word.
    in_q.push_back(32'h000000EC);
    bus.in_req = 1'b1;
    send_rx(8'h00); send_rx(8'h00); send_rx(8'h00); send_rx(8'hEC);
    wait_in_done();
    repeat (2) tick();

    // Hold register: one early byte.
    send_rx(8'hA5);
    repeat (2) tick();
    in_q.push_back(32'hA5112233);
    bus.in_req = 1'b1;
    send_rx(8'h11); send_rx(8'h22); send_rx(8'h33);
    wait_in_done();
    check("overrun_after_single_hold", 32'(bus.rx_overrun), 32'd0);
    repeat (2) tick();

    // Byte arriving in the acceptance cycle counts as byte 0.
    in_q.push_back(32'hC3010203);
    tick();
    bus.in_req   = 1'b1;
    bus.rx_data  = 8'hC3;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    send_rx(8'h01); send_rx(8'h02); send_rx(8'h03);
    wait_in_done();
    check("overrun_after_simultaneous", 32'(bus.rx_overrun), 32'd0);
    repeat (2) tick();

    // Two early bytes: second overwrites, overrun sticks.
    send_rx(8'h5A);
    send_rx(8'h66);
    tick();
    check("overrun_after_two_holds", 32'(bus.rx_overrun), 32'd1);
    in_q.push_back(32'h66778899);
    bus.in_req = 1'b1;
    send_rx(8'h77); send_rx(8'h88); send_rx(8'h99);
    wait_in_done();
    repeat (2) tick();

    // Abort via load_mode after two bytes, then a clean word.
    bus.in_req = 1'b1;
    send_rx(8'h12); send_rx(8'h34);
    tick();
    bus.load_mode = 1'b1;
    bus.in_req    = 1'b0;
    repeat (3) tick();
    bus.load_mode = 1'b0;
    tick();
    in_q.push_back(32'h0A0B0C0D);
    bus.in_req = 1'b1;
    send_rx(8'h0A); send_rx(8'h0B); send_rx(8'h0C); send_rx(8'h0D);
    wait_in_done();
    repeat (2) tick();

    // OUT words.
    tx_q.push_back(8'h00); tx_q.push_back(8'h00); tx_q.push_back(8'h00); tx_q.push_back(8'hF0);
    done_q.push_back(4);
    bus.out_word = 32'h000000F0;
    bus.out_req  = 1'b1;
    tick();
    bus.out_req  = 1'b0;
    wait_out_done();
    repeat (2) tick();

    tx_q.push_back(8'h12); tx_q.push_back(8'h34); tx_q.push_back(8'h56); tx_q.push_back(8'h78);
    done_q.push_back(4);
    bus.out_word = 32'h12345678;
    bus.out_req  = 1'b1;
    tick();
    bus.out_req  = 1'b0;
    wait_out_done();
    repeat (2) tick();

    // Reset with RX mid-word and TX in the ack phase of byte 2.
    bus.in_req = 1'b1;
    send_rx(8'h55); send_rx(8'h66);
    tx_q.push_back(8'hDE); tx_q.push_back(8'hAD); tx_q.push_back(8'hBE);
    bus.out_word = 32'hDEADBEEF;
    bus.out_req  = 1'b1;
    tick();
    bus.out_req  = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300 && cnt < 3; i++) begin
      @(negedge CLK);
      #1;
      if (bus.tx_enable) cnt++;
    end
    if (cnt < 3) flag("third_tx_enable_timeout");
    RST = 1'b1;
    @(negedge CLK);
    #1;
    check_outputs_zero("midrun_reset");
    RST        = 1'b0;
    bus.in_req = 1'b0;
    repeat (2) tick();

    // After reset the IN path starts again from byte 0.
    in_q.push_back(32'h01020304);
    bus.in_req = 1'b1;
    send_rx(8'h01); send_rx(8'h02); send_rx(8'h03); send_rx(8'h04);
    wait_in_done();

    cnt = 0;
    while (!bus.tx_ready && cnt < 100) begin
      tick();
      cnt++;
    end
    repeat (4) tick();
    check("ld_q_drained",   32'(ld_q.size()),   32'd0);
    check("in_q_drained",   32'(in_q.size()),   32'd0);
    check("tx_q_drained",   32'(tx_q.size()),   32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
